// File: rtl/ysyx_23060332_ifu.sv
// ysyx_23060332_ifu -- instruction fetch unit for the NPC core.
//
// Holds the PC, fetches one 32-bit word at a time from instruction memory and
// presents it to the decoder.
//
// Ports:
//   clk, rst_n            core clock; asynchronous active-low reset
//   araddr/arvalid/arready            read-address channel to instruction memory
//   rdata/rresp/rvalid/rready         read-data channel from instruction memory
//   inst_o/inst_addr_o/inst_valid/inst_ready  instruction + PC to the decoder
//   jump_en/jump_addr     next-PC redirect from the EXU, sampled on the
//                         decoder handshake only
//   fetch_err             sticky fault (bus error or misaligned redirect)
//   fetch_cnt             instructions handed to the decoder (wraps)
//
// Handshake rule for all three channels: a transfer happens on a rising edge
// where valid && ready are both high; the producer keeps valid and its payload
// stable until that edge and never withdraws valid early.
//
// Every output is either a register or a decode of the state register, so no
// input reaches an output combinationally.

module ysyx_23060332_ifu #(
   parameter int                ADDR_W   = 32,
   parameter int                DATA_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = 32'h8000_0000
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic [ADDR_W-1:0] araddr,
   output logic              arvalid,
   input  logic              arready,
   input  logic [DATA_W-1:0] rdata,
   input  logic [1:0]        rresp,
   input  logic              rvalid,
   output logic              rready,
   output logic [DATA_W-1:0] inst_o,
   output logic [ADDR_W-1:0] inst_addr_o,
   output logic              inst_valid,
   input  logic              inst_ready,
   input  logic              jump_en,
   input  logic [ADDR_W-1:0] jump_addr,
   output logic              fetch_err,
   output logic [31:0]       fetch_cnt
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR,
      S_DATA,
      S_HOLD,
      S_ERR
   } state_t;

   localparam logic [ADDR_W-1:0] PC_STEP = {{(ADDR_W-3){1'b0}}, 3'd4};

   state_t            state;
   state_t            state_nx;
   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] pc_nx;
   logic              data_hs;
   logic              inst_hs;

   // Only an OK response is captured; an error response moves to ERR instead.
   assign data_hs = (state == S_DATA) && rvalid && (rresp == 2'b00);
   assign inst_hs = (state == S_HOLD) && inst_ready;

   always_comb begin
      state_nx = state;
      pc_nx    = pc;
      case (state)
         S_IDLE: state_nx = S_ADDR;
         S_ADDR: if (arready) state_nx = S_DATA;
         S_DATA: begin
            if (rvalid) state_nx = (rresp == 2'b00) ? S_HOLD : S_ERR;
         end
         S_HOLD: begin
            if (inst_ready) begin
               if (jump_en) begin
                  // pc takes the target even when misaligned so the fault
                  // address stays visible on araddr while parked in ERR.
                  pc_nx    = jump_addr;
                  state_nx = (jump_addr[1:0] != 2'b00) ? S_ERR : S_ADDR;
               end else begin
                  pc_nx    = pc + PC_STEP;
                  state_nx = S_ADDR;
               end
            end
         end
         S_ERR:   state_nx = S_ERR;
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         pc          <= RESET_PC;
         inst_o      <= '0;
         inst_addr_o <= RESET_PC;
         fetch_cnt   <= '0;
      end else begin
         state <= state_nx;
         pc    <= pc_nx;
         if (data_hs) begin
            inst_o      <= rdata;
            inst_addr_o <= pc;
         end
         if (inst_hs) fetch_cnt <= fetch_cnt + 32'd1;
      end
   end

   assign araddr     = pc;
   assign arvalid    = (state == S_ADDR);
   assign rready     = (state == S_DATA);
   assign inst_valid = (state == S_HOLD);
   assign fetch_err  = (state == S_ERR);

endmodule

// File: tb/tb_ysyx_23060332_ifu.sv
// Testbench for ysyx_23060332_ifu: directed vector table, randomized fetch
// stream against a PC/count reference model, error, async reset and PC-wrap
// sequences. Inputs change and outputs are sampled on the falling clock edge.

module tb_ysyx_23060332_ifu;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic [31:0] araddr;
   logic        arvalid;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready;
   logic [31:0] inst_o;
   logic [31:0] inst_addr_o;
   logic        inst_valid;
   logic        inst_ready;
   logic        jump_en;
   logic [31:0] jump_addr;
   logic        fetch_err;
   logic [31:0] fetch_cnt;

   ysyx_23060332_ifu dut (
      .clk(clk), .rst_n(rst_n),
      .araddr(araddr), .arvalid(arvalid), .arready(arready),
      .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
      .inst_o(inst_o), .inst_addr_o(inst_addr_o), .inst_valid(inst_valid),
      .inst_ready(inst_ready), .jump_en(jump_en), .jump_addr(jump_addr),
      .fetch_err(fetch_err), .fetch_cnt(fetch_cnt)
   );

   // Second instance for the PC wrap case; memory always ready, decoder always ready.
   logic        w_rst_n;
   logic [31:0] w_araddr;
   logic        w_arvalid;
   logic        w_rready;
   logic [31:0] w_inst_o;
   logic [31:0] w_inst_addr_o;
   logic        w_inst_valid;
   logic        w_fetch_err;
   logic [31:0] w_fetch_cnt;

   ysyx_23060332_ifu #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
      .clk(clk), .rst_n(w_rst_n),
      .araddr(w_araddr), .arvalid(w_arvalid), .arready(1'b1),
      .rdata(32'h0000_0013), .rresp(2'b00), .rvalid(1'b1), .rready(w_rready),
      .inst_o(w_inst_o), .inst_addr_o(w_inst_addr_o), .inst_valid(w_inst_valid),
      .inst_ready(1'b1), .jump_en(1'b0), .jump_addr(32'h0),
      .fetch_err(w_fetch_err), .fetch_cnt(w_fetch_cnt)
   );

   // ---------------- scoreboard / model ----------------
   int          errors = 0;
   int          checks = 0;
   logic [31:0] exp_pc;   // model: address of the next fetch
   logic [31:0] exp_cnt;  // model: instructions handed over since reset
   logic [31:0] exp_q[$]; // expected araddr values for the random phase

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Memory contents: two fixed words, everything else derived from the address.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h8000_0000) return 32'h0000_0013;
      if (a == 32'h8000_0004) return 32'h0010_0093;
      return (a * 32'd2654435761) ^ 32'h5A5A_0013;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic idle_inputs();
      arready = 0; rvalid = 0; rdata = 0; rresp = 0;
      inst_ready = 0; jump_en = 0; jump_addr = 0;
   endtask

   task automatic junk_jump();
      jump_en   = 1'($urandom_range(0, 1));
      jump_addr = $urandom;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      idle_inputs();
      rst_n = 0;
      repeat (2) @(negedge clk);
      rst_n = 1;
      exp_pc  = 32'h8000_0000;
      exp_cnt = 0;
   endtask

   // One complete fetch with programmable stalls on every channel.
   task automatic fetch_one(input int ar_w, input int r_w, input int d_w,
                            input logic jen, input logic [31:0] jaddr,
                            input logic [31:0] exp_addr, input logic [1:0] resp);
      int n;
      logic [31:0] data;
      data = mem_word(exp_addr);
      n = 0;
      while (!arvalid && n < 8) begin
         @(negedge clk);
         n++;
      end
      check("arvalid_up", {31'b0, arvalid}, 32'd1);
      check("araddr", araddr, exp_addr);
      for (int i = 0; i < ar_w; i++) begin
         arready = 0; junk_jump();
         rvalid = 1'($urandom_range(0, 1)); rdata = $urandom;
         @(negedge clk);
         check("arvalid_hold", {31'b0, arvalid}, 32'd1);
         check("araddr_hold", araddr, exp_addr);
         check("rready_addr", {31'b0, rready}, 32'd0);
      end
      arready = 1; rvalid = 0; junk_jump();
      @(negedge clk);
      arready = 0;
      check("rready_up", {31'b0, rready}, 32'd1);
      check("arvalid_drop", {31'b0, arvalid}, 32'd0);
      for (int i = 0; i < r_w; i++) begin
         rvalid = 0; rdata = $urandom; junk_jump();
         @(negedge clk);
         check("rready_hold", {31'b0, rready}, 32'd1);
      end
      rvalid = 1; rdata = data; rresp = resp; junk_jump();
      @(negedge clk);
      rvalid = 0; rresp = 0; rdata = $urandom; jump_en = 0;
      if (resp != 2'b00) begin
         check("berr_fetch_err", {31'b0, fetch_err}, 32'd1);
         check("berr_valids", {29'b0, arvalid, rready, inst_valid}, 32'd0);
         return;
      end
      check("inst_valid_up", {31'b0, inst_valid}, 32'd1);
      check("inst_o", inst_o, data);
      check("inst_addr_o", inst_addr_o, exp_addr);
      for (int i = 0; i < d_w; i++) begin
         inst_ready = 0; junk_jump();
         rvalid = 1'($urandom_range(0, 1)); rdata = $urandom;
         @(negedge clk);
         check("inst_valid_hold", {31'b0, inst_valid}, 32'd1);
         check("inst_o_hold", inst_o, data);
         check("inst_addr_hold", inst_addr_o, exp_addr);
      end
      inst_ready = 1; jump_en = jen; jump_addr = jaddr; rvalid = 0;
      @(negedge clk);
      inst_ready = 0; jump_en = 0;
      exp_cnt = exp_cnt + 32'd1;
      check("fetch_cnt", fetch_cnt, exp_cnt);
      check("inst_valid_drop", {31'b0, inst_valid}, 32'd0);
   endtask

   task automatic check_parked(input string name, input logic [31:0] exp_araddr);
      for (int i = 0; i < 20; i++) begin
         arready = 1'($urandom_range(0, 1)); rvalid = 1'($urandom_range(0, 1));
         inst_ready = 1'($urandom_range(0, 1)); junk_jump();
         @(negedge clk);
         check({name, "_err"}, {31'b0, fetch_err}, 32'd1);
         check({name, "_valids"}, {29'b0, arvalid, rready, inst_valid}, 32'd0);
      end
      check({name, "_pc"}, araddr, exp_araddr);
      idle_inputs();
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      int          ar_w;
      int          r_w;
      int          d_w;
      logic        jen;
      logic [31:0] jaddr;
      logic [31:0] exp_addr;
   } vec_t;

   vec_t vecs[5];

   initial begin
      int n;
      vecs[0] = '{0, 0, 0, 1'b0, 32'h0,         32'h8000_0000};
      vecs[1] = '{0, 0, 0, 1'b0, 32'h0,         32'h8000_0004};
      vecs[2] = '{3, 4, 5, 1'b1, 32'h8000_0100, 32'h8000_0008};
      vecs[3] = '{0, 0, 0, 1'b0, 32'h0,         32'h8000_0100};
      vecs[4] = '{1, 2, 0, 1'b0, 32'h0,         32'h8000_0104};

      idle_inputs();
      w_rst_n = 0;
      rst_n = 0;
      #12;
      check("rst_araddr", araddr, 32'h8000_0000);
      check("rst_valids", {29'b0, arvalid, rready, inst_valid}, 32'd0);
      check("rst_inst_o", inst_o, 32'h0);
      check("rst_inst_addr", inst_addr_o, 32'h8000_0000);
      check("rst_fetch_err", {31'b0, fetch_err}, 32'd0);
      check("rst_fetch_cnt", fetch_cnt, 32'd0);
      apply_reset();
      check("idle_no_arvalid", {31'b0, arvalid}, 32'd0);

      for (int v = 0; v < 5; v++)
         fetch_one(vecs[v].ar_w, vecs[v].r_w, vecs[v].d_w, vecs[v].jen,
                   vecs[v].jaddr, vecs[v].exp_addr, 2'b00);
      check("cnt_after_table", fetch_cnt, 32'd5);
      exp_pc = 32'h8000_0108;

      // Randomized stream: model computes each next PC from the redirect rule.
      for (int t = 0; t < 40; t++) begin
         logic        jen;
         logic [31:0] jaddr;
         jen   = ($urandom_range(0, 3) == 0);
         jaddr = 32'h8000_0000 | (32'($urandom_range(0, 1023)) << 2);
         exp_q.push_back(exp_pc);
         fetch_one($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                   jen, jaddr, exp_q.pop_front(), 2'b00);
         exp_pc = jen ? jaddr : exp_pc + 32'd4;
      end

      // Async reset while waiting in DATA.
      n = 0;
      while (!arvalid && n < 8) begin
         @(negedge clk);
         n++;
      end
      arready = 1;
      @(negedge clk);
      arready = 0;
      check("pre_reset_rready", {31'b0, rready}, 32'd1);
      #2 rst_n = 0;
      #1;
      check("async_inst_addr", inst_addr_o, 32'h8000_0000);
      check("async_fetch_cnt", fetch_cnt, 32'd0);
      check("async_araddr", araddr, 32'h8000_0000);
      check("async_valids", {29'b0, arvalid, rready, inst_valid}, 32'd0);
      @(negedge clk);
      rst_n = 1;
      exp_cnt = 0;
      check("rel_no_arvalid", {31'b0, arvalid}, 32'd0);
      @(posedge clk);
      #1;
      check("rel_arvalid", {31'b0, arvalid}, 32'd1);
      @(negedge clk);
      fetch_one(0, 0, 0, 1'b0, 32'h0, 32'h8000_0000, 2'b00);

      // Misaligned redirect.
      fetch_one(1, 0, 1, 1'b1, 32'h8000_0102, 32'h8000_0004, 2'b00);
      check_parked("misalign", 32'h8000_0102);

      // Bus error response.
      apply_reset();
      fetch_one(0, 1, 0, 1'b0, 32'h0, 32'h8000_0000, 2'b10);
      check_parked("buserr", 32'h8000_0000);

      // PC wrap on the second instance.
      @(negedge clk);
      w_rst_n = 1;
      n = 0;
      while (!w_arvalid && n < 8) begin
         @(negedge clk);
         n++;
      end
      check("wrap_first_araddr", w_araddr, 32'hFFFF_FFFC);
      n = 0;
      while (!w_inst_valid && n < 8) begin
         @(negedge clk);
         n++;
      end
      check("wrap_inst_addr", w_inst_addr_o, 32'hFFFF_FFFC);
      @(negedge clk);
      n = 0;
      while (!w_arvalid && n < 8) begin
         @(negedge clk);
         n++;
      end
      check("wrap_next_araddr", w_araddr, 32'h0000_0000);
      check("wrap_cnt", w_fetch_cnt, 32'd1);
      check("wrap_no_err", {31'b0, w_fetch_err}, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Global time bound so the bench always ends.
   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
